// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader: parses a UART byte stream (header, X, A) into memory writes, then starts the compute core.
module matrix_stream_loader #(
  parameter int DATA_W      = 8,
  parameter int MAX_LOG2N   = 6,
  parameter int X_AW        = MAX_LOG2N,
  parameter int A_AW        = 2*MAX_LOG2N,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic [7:0]           rx_byte_in,
  input  logic                 rx_dv_in,
  output logic                 x_en_out,
  output logic                 x_we_out,
  output logic [DATA_W-1:0]    x_din_out,
  output logic [X_AW-1:0]      x_addr_out,
  output logic                 a_en_out,
  output logic                 a_we_out,
  output logic [DATA_W-1:0]    a_din_out,
  output logic [A_AW-1:0]      a_addr_out,
  output logic [MAX_LOG2N:0]   n_out,
  output logic                 n_valid_out,
  output logic                 start_out,
  input  logic                 done_in,
  output logic                 busy_out,
  output logic                 err_out,
  output logic [1:0]           err_code_out
);
  localparam int EB = DATA_W/8;
  localparam int IW = 2*MAX_LOG2N+1;
  localparam int KW = $clog2(MAX_LOG2N+1);
  localparam int BW = EB > 1 ? $clog2(EB) : 1;
  localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC+1) : 1;
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC-1 : 0);
  typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_A, START, WAIT} state_t;
  state_t state;
  logic [KW-1:0] k;
  logic [IW-1:0] idx;
  logic [BW-1:0] bcnt;
  logic [TW-1:0] tcnt;
  logic [DATA_W-1:0] acc, nxt;
  logic last_byte, last_x, last_a, loading, tmo, hdr_ok;
  assign nxt = (acc << 8) | DATA_W'(rx_byte_in);
  assign last_byte = bcnt == BW'(EB-1);
  assign last_x = idx == (IW'(1) << k) - IW'(1);
  assign last_a = idx == (IW'(1) << {k, 1'b0}) - IW'(1);
  assign loading = state == LOAD_X || state == LOAD_A;
  assign tmo = TIMEOUT_CYC > 0 && loading && !rx_dv_in && tcnt == TLIM;
  assign hdr_ok = rx_byte_in >= 8'd1 && rx_byte_in <= 8'(MAX_LOG2N);
  assign busy_out = state != IDLE;
  always_ff @(posedge clk) begin
    if (RST) begin
      state <= IDLE;
      k <= '0;
      idx <= '0;
      bcnt <= '0;
      tcnt <= '0;
      acc <= '0;
      x_en_out <= 1'b0;
      x_we_out <= 1'b0;
      x_din_out <= '0;
      x_addr_out <= '0;
      a_en_out <= 1'b0;
      a_we_out <= 1'b0;
      a_din_out <= '0;
      a_addr_out <= '0;
      n_out <= '0;
      n_valid_out <= 1'b0;
      start_out <= 1'b0;
      err_out <= 1'b0;
      err_code_out <= 2'd0;
    end else begin
      x_en_out <= 1'b0;
      x_we_out <= 1'b0;
      a_en_out <= 1'b0;
      a_we_out <= 1'b0;
      start_out <= 1'b0;
      err_out <= 1'b0;
      tcnt <= (loading && !rx_dv_in) ? tcnt + TW'(1) : '0;
      if (tmo) begin
        err_out <= 1'b1;
        err_code_out <= 2'd2;
        state <= IDLE;
        n_valid_out <= 1'b0;
        idx <= '0;
        bcnt <= '0;
        acc <= '0;
      end else begin
        case (state)
          IDLE: if (rx_dv_in) begin
            if (hdr_ok) begin
              k <= rx_byte_in[KW-1:0];
              n_out <= (MAX_LOG2N+1)'(1) << rx_byte_in[KW-1:0];
              n_valid_out <= 1'b1;
              idx <= '0;
              bcnt <= '0;
              state <= LOAD_X;
            end else begin
              err_out <= 1'b1;
              err_code_out <= 2'd1;
            end
          end
          LOAD_X, LOAD_A: if (rx_dv_in) begin
            acc <= nxt;
            bcnt <= last_byte ? '0 : bcnt + BW'(1);
            if (last_byte && state == LOAD_X) begin
              x_en_out <= 1'b1;
              x_we_out <= 1'b1;
              x_din_out <= nxt;
              x_addr_out <= X_AW'(idx);
              idx <= last_x ? '0 : idx + IW'(1);
              if (last_x) state <= LOAD_A;
            end else if (last_byte) begin
              a_en_out <= 1'b1;
              a_we_out <= 1'b1;
              a_din_out <= nxt;
              a_addr_out <= A_AW'(idx);
              idx <= last_a ? '0 : idx + IW'(1);
              if (last_a) state <= START;
            end
          end
          START: begin
            start_out <= 1'b1;
            state <= WAIT;
            if (rx_dv_in) begin
              err_out <= 1'b1;
              err_code_out <= 2'd3;
            end
          end
          WAIT: begin
            if (rx_dv_in) begin
              err_out <= 1'b1;
              err_code_out <= 2'd3;
            end else if (done_in) begin
              state <= IDLE;
              n_valid_out <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_matrix_stream_loader.sv
// tb_matrix_stream_loader: directed checks on an 8-bit and a 16-bit instance of matrix_stream_loader.
module tb_matrix_stream_loader;
  logic clk = 1'b0;
  logic RST = 1'b1;
  always #5 clk = ~clk;
  logic [7:0] rx8 = '0, rx16 = '0;
  logic dv8 = 1'b0, dv16 = 1'b0, done8 = 1'b0, done16 = 1'b0;
  logic x_en8, x_we8, a_en8, a_we8, nv8, st8, busy8, err8;
  logic [7:0] x_din8, a_din8;
  logic [2:0] x_addr8;
  logic [5:0] a_addr8;
  logic [3:0] n8;
  logic [1:0] ec8;
  logic x_en16, x_we16, a_en16, a_we16, nv16, st16, busy16, err16;
  logic [15:0] x_din16, a_din16;
  logic [2:0] x_addr16;
  logic [5:0] a_addr16;
  logic [3:0] n16;
  logic [1:0] ec16;
  int checks = 0, errors = 0;
  matrix_stream_loader #(.DATA_W(8), .MAX_LOG2N(3), .TIMEOUT_CYC(20)) dut8 (
    .clk(clk), .RST(RST), .rx_byte_in(rx8), .rx_dv_in(dv8),
    .x_en_out(x_en8), .x_we_out(x_we8), .x_din_out(x_din8), .x_addr_out(x_addr8),
    .a_en_out(a_en8), .a_we_out(a_we8), .a_din_out(a_din8), .a_addr_out(a_addr8),
    .n_out(n8), .n_valid_out(nv8), .start_out(st8), .done_in(done8),
    .busy_out(busy8), .err_out(err8), .err_code_out(ec8));
  matrix_stream_loader #(.DATA_W(16), .MAX_LOG2N(3), .TIMEOUT_CYC(20)) dut16 (
    .clk(clk), .RST(RST), .rx_byte_in(rx16), .rx_dv_in(dv16),
    .x_en_out(x_en16), .x_we_out(x_we16), .x_din_out(x_din16), .x_addr_out(x_addr16),
    .a_en_out(a_en16), .a_we_out(a_we16), .a_din_out(a_din16), .a_addr_out(a_addr16),
    .n_out(n16), .n_valid_out(nv16), .start_out(st16), .done_in(done16),
    .busy_out(busy16), .err_out(err16), .err_code_out(ec16));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic send8(input logic [7:0] b);
    @(negedge clk);
    rx8 = b;
    dv8 = 1'b1;
    @(negedge clk);
    dv8 = 1'b0;
  endtask
  task automatic send16(input logic [7:0] b);
    @(negedge clk);
    rx16 = b;
    dv16 = 1'b1;
    @(negedge clk);
    dv16 = 1'b0;
  endtask
  initial begin
    logic [7:0] a_vals [4];
    a_vals = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    repeat (3) tick();
    RST = 1'b0;
    chk("rst_busy", busy8, 0);
    chk("rst_nvalid", nv8, 0);
    chk("rst_xen", x_en8, 0);
    chk("rst_errcode", ec8, 0);
    chk("rst_start", st8, 0);
    send8(8'h01);
    chk("hdr_n", n8, 2);
    chk("hdr_nvalid", nv8, 1);
    chk("hdr_busy", busy8, 1);
    chk("hdr_no_xen", x_en8, 0);
    send8(8'h11);
    chk("x0_en", x_en8, 1);
    chk("x0_we", x_we8, 1);
    chk("x0_din", x_din8, 8'h11);
    chk("x0_addr", x_addr8, 0);
    tick();
    chk("x0_en_drop", x_en8, 0);
    chk("x0_din_hold", x_din8, 8'h11);
    send8(8'h22);
    chk("x1_din", x_din8, 8'h22);
    chk("x1_addr", x_addr8, 1);
    for (int i = 0; i < 4; i++) begin
      send8(a_vals[i]);
      chk($sformatf("a%0d_en", i), a_en8, 1);
      chk($sformatf("a%0d_din", i), a_din8, a_vals[i]);
      chk($sformatf("a%0d_addr", i), a_addr8, i);
      chk($sformatf("a%0d_no_xen", i), x_en8, 0);
    end
    chk("start_not_yet", st8, 0);
    tick();
    chk("start_pulse", st8, 1);
    chk("start_a_en_drop", a_en8, 0);
    tick();
    chk("start_done", st8, 0);
    chk("wait_busy", busy8, 1);
    send8(8'h55);
    chk("ovr_err", err8, 1);
    chk("ovr_code", ec8, 3);
    chk("ovr_no_xen", x_en8, 0);
    chk("ovr_no_aen", a_en8, 0);
    chk("ovr_busy", busy8, 1);
    tick();
    chk("ovr_err_drop", err8, 0);
    chk("ovr_still_wait", busy8, 1);
    @(negedge clk);
    done8 = 1'b1;
    @(negedge clk);
    done8 = 1'b0;
    chk("done_busy", busy8, 0);
    chk("done_nvalid", nv8, 0);
    send8(8'h00);
    chk("hdr0_err", err8, 1);
    chk("hdr0_code", ec8, 1);
    chk("hdr0_busy", busy8, 0);
    tick();
    chk("hdr0_err_drop", err8, 0);
    send8(8'h04);
    chk("hdrmax_err", err8, 1);
    chk("hdrmax_code", ec8, 1);
    chk("hdrmax_busy", busy8, 0);
    chk("hdrmax_nvalid", nv8, 0);
    chk("hdrmax_no_xen", x_en8, 0);
    send8(8'h01);
    send8(8'h77);
    chk("to_x0", x_din8, 8'h77);
    repeat (19) tick();
    chk("to_not_yet", busy8, 1);
    tick();
    chk("to_err", err8, 1);
    chk("to_code", ec8, 2);
    chk("to_busy", busy8, 0);
    chk("to_nvalid", nv8, 0);
    send8(8'h01);
    send8(8'h33);
    chk("fresh_addr", x_addr8, 0);
    chk("fresh_din", x_din8, 8'h33);
    send8(8'h44);
    send8(8'hB0);
    chk("midA_a0", a_din8, 8'hB0);
    @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    chk("rstmid_busy", busy8, 0);
    chk("rstmid_xdin", x_din8, 0);
    chk("rstmid_xaddr", x_addr8, 0);
    chk("rstmid_adin", a_din8, 0);
    chk("rstmid_n", n8, 0);
    chk("rstmid_code", ec8, 0);
    send8(8'h02);
    chk("re_n", n8, 4);
    send8(8'h99);
    chk("re_addr", x_addr8, 0);
    chk("re_din", x_din8, 8'h99);
    chk("re_en", x_en8, 1);
    send16(8'h01);
    chk("w16_n", n16, 2);
    send16(8'h12);
    chk("w16_half_no_en", x_en16, 0);
    send16(8'h34);
    chk("w16_en", x_en16, 1);
    chk("w16_din", x_din16, 16'h1234);
    chk("w16_addr", x_addr16, 0);
    tick();
    chk("w16_en_drop", x_en16, 0);
    send16(8'hAB);
    send16(8'hCD);
    chk("w16_x1_din", x_din16, 16'hABCD);
    chk("w16_x1_addr", x_addr16, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
